// File: rtl/leaf_bridge_pkg.sv
// Shared packet geometry and helpers for the BFT leaf stream bridge.
// Offsets describe the default 49-bit packet {valid, leaf, port, addr, payload}.
package leaf_bridge_pkg;

  localparam int unsigned DEF_PAYLOAD_BITS  = 32;
  localparam int unsigned DEF_LEAF_BITS     = 5;
  localparam int unsigned DEF_PORT_BITS     = 4;
  localparam int unsigned DEF_ADDR_BITS     = 7;
  localparam int unsigned DEF_PACKET_BITS   =
      1 + DEF_LEAF_BITS + DEF_PORT_BITS + DEF_ADDR_BITS + DEF_PAYLOAD_BITS;

  localparam int unsigned ADDR_LSB  = DEF_PAYLOAD_BITS;
  localparam int unsigned PORT_LSB  = ADDR_LSB + DEF_ADDR_BITS;
  localparam int unsigned LEAF_LSB  = PORT_LSB + DEF_PORT_BITS;
  localparam int unsigned VALID_BIT = LEAF_LSB + DEF_LEAF_BITS;

  // Port 0 on the inbound side carries destination-table writes.
  localparam int unsigned CFG_PORT = 0;

  typedef logic [DEF_PACKET_BITS-1:0] packet_t;

  function automatic packet_t pack_packet(input logic                        valid,
                                          input logic [DEF_LEAF_BITS-1:0]    leaf,
                                          input logic [DEF_PORT_BITS-1:0]    port,
                                          input logic [DEF_ADDR_BITS-1:0]    addr,
                                          input logic [DEF_PAYLOAD_BITS-1:0] payload);
    return {valid, leaf, port, addr, payload};
  endfunction

endpackage

// File: rtl/leaf_bridge_fifo.sv
// Show-ahead synchronous FIFO: head word is visible whenever not empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module leaf_bridge_fifo #(
  parameter int unsigned Width    = 32,
  parameter int unsigned AddrBits = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 1 << AddrBits;

  logic [Width-1:0]    mem_q [Depth];
  logic [AddrBits-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrBits:0]   count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == (AddrBits + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Bridges one BFT leaf port to buffered inbound and round-robin outbound user channels.
// Define LEAF_BRIDGE_STATS_EN to add pkt_in_cnt / pkt_out_cnt traffic counters.
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS   = 32,
  parameter int unsigned NUM_LEAF_BITS  = 5,
  parameter int unsigned NUM_PORT_BITS  = 4,
  parameter int unsigned NUM_ADDR_BITS  = 7,
  parameter int unsigned PACKET_BITS    = 49,
  parameter int unsigned NUM_IN_PORTS   = 2,
  parameter int unsigned NUM_OUT_PORTS  = 4,
  parameter int unsigned FIFO_ADDR_BITS = 3
) (
  input  logic                                  clk,
  input  logic                                  ap_rst_n,
  input  logic [PACKET_BITS-1:0]                din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  bft_ready,
  input  logic                                  ap_start,
  output logic                                  ap_start_user,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  output logic [NUM_IN_PORTS-1:0]               vld_interface2user,
  input  logic [NUM_IN_PORTS-1:0]               ack_user2interface,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [NUM_IN_PORTS-1:0]               overflow
`ifdef LEAF_BRIDGE_STATS_EN
  ,
  output logic [31:0]                           pkt_in_cnt,
  output logic [31:0]                           pkt_out_cnt
`endif
);

  localparam int unsigned DestBits   = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int unsigned AddrLsb    = PAYLOAD_BITS;
  localparam int unsigned PortLsb    = AddrLsb + NUM_ADDR_BITS;
  localparam int unsigned LeafLsb    = PortLsb + NUM_PORT_BITS;
  localparam int unsigned OutIdxBits = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  if (PACKET_BITS != 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS)
  begin : g_bad_packet_bits
    $error("PACKET_BITS does not match the sum of its fields");
  end

  // Inbound field decode
  logic                     in_vld;
  logic [NUM_PORT_BITS-1:0] in_port;
  logic [NUM_ADDR_BITS-1:0] in_addr;
  logic [PAYLOAD_BITS-1:0]  in_payload;
  logic                     cfg_wr;
  logic                     unused_in_leaf;

  assign in_vld         = din_leaf_bft2interface[PACKET_BITS-1];
  assign in_port        = din_leaf_bft2interface[PortLsb +: NUM_PORT_BITS];
  assign in_addr        = din_leaf_bft2interface[AddrLsb +: NUM_ADDR_BITS];
  assign in_payload     = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  assign unused_in_leaf = ^din_leaf_bft2interface[LeafLsb +: NUM_LEAF_BITS];

  assign cfg_wr = in_vld && (in_port == NUM_PORT_BITS'(CFG_PORT)) &&
                  (32'(in_addr) < NUM_OUT_PORTS);

  // Inbound FIFOs, one per user channel; channel p listens on leaf port p+1
  logic [NUM_IN_PORTS-1:0] in_drop, in_accept;

  for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_in
    logic push, pop, full, empty;

    assign push = in_vld && (in_port == NUM_PORT_BITS'(p + 1));
    assign pop  = vld_interface2user[p] && ack_user2interface[p];

    leaf_bridge_fifo #(
      .Width    (PAYLOAD_BITS),
      .AddrBits (FIFO_ADDR_BITS)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (ap_rst_n),
      .push_i  (push),
      .wdata_i (in_payload),
      .pop_i   (pop),
      .rdata_o (dout_leaf_interface2user[p*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full_o  (full),
      .empty_o (empty)
    );

    assign vld_interface2user[p] = !empty;
    assign in_drop[p]            = push && full && !pop;
    assign in_accept[p]          = push && !in_drop[p];
  end

  // Outbound state
  logic [DestBits-1:0]      dest_q [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] dest_vld_q;
  logic [NUM_ADDR_BITS-1:0] seq_q  [NUM_OUT_PORTS];
  logic [OutIdxBits-1:0]    rr_q, rr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [NUM_IN_PORTS-1:0]  overflow_q;
  logic                     ap_start_q;

  logic [NUM_OUT_PORTS-1:0] elig, gnt;
  logic                     found;

  assign elig = vld_user2interface & dest_vld_q & {NUM_OUT_PORTS{bft_ready}};

  // Round robin: search from rr_q upward, then wrap to the low channels.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!found && elig[i] && (i >= int'(rr_q))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!found && elig[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    dout_d = '0;
    rr_d   = rr_q;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (gnt[i]) begin
        dout_d = {1'b1, dest_q[i], seq_q[i],
                  din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
        rr_d   = (i == NUM_OUT_PORTS - 1) ? '0 : OutIdxBits'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_q[i] <= '0;
        seq_q[i]  <= '0;
      end
      dest_vld_q <= '0;
      rr_q       <= '0;
      dout_q     <= '0;
      overflow_q <= '0;
      ap_start_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        // A rewrite while the channel is granted only affects later grants.
        if (cfg_wr && (in_addr == NUM_ADDR_BITS'(i))) begin
          dest_q[i]     <= in_payload[DestBits-1:0];
          dest_vld_q[i] <= 1'b1;
        end
        if (gnt[i]) seq_q[i] <= seq_q[i] + 1'b1;
      end
      rr_q       <= rr_d;
      dout_q     <= dout_d;
      overflow_q <= overflow_q | in_drop;
      ap_start_q <= ap_start;
    end
  end

  assign ack_interface2user      = gnt;
  assign dout_leaf_interface2bft = dout_q;
  assign overflow                = overflow_q;
  assign ap_start_user           = ap_start_q;

`ifdef LEAF_BRIDGE_STATS_EN
  logic [31:0] pkt_in_cnt_q, pkt_out_cnt_q;

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pkt_in_cnt_q  <= '0;
      pkt_out_cnt_q <= '0;
    end else begin
      if (|in_accept) pkt_in_cnt_q  <= pkt_in_cnt_q + 1'b1;
      if (|gnt)       pkt_out_cnt_q <= pkt_out_cnt_q + 1'b1;
    end
  end

  assign pkt_in_cnt  = pkt_in_cnt_q;
  assign pkt_out_cnt = pkt_out_cnt_q;
`else
  logic unused_in_accept;
  assign unused_in_accept = ^in_accept;
`endif

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Directed bench for leaf_stream_bridge: config, inbound FIFOs, round robin, seq wrap, reset.
// Inputs change on the falling edge; outputs are sampled on or just after it.
module tb_leaf_stream_bridge;

  localparam int PB = 49;

  logic          clk = 1'b0;
  logic          ap_rst_n;
  logic [PB-1:0] din_bft;
  logic [PB-1:0] dout_bft;
  logic          bft_ready;
  logic          ap_start;
  logic          ap_start_user;
  logic [63:0]   dout_user;
  logic [1:0]    vld_i2u;
  logic [1:0]    ack_u2i;
  logic [127:0]  din_user;
  logic [3:0]    vld_u2i;
  logic [3:0]    ack_i2u;
  logic [1:0]    overflow;
`ifdef LEAF_BRIDGE_STATS_EN
  logic [31:0]   pkt_in_cnt, pkt_out_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leaf_stream_bridge dut (
    .clk                      (clk),
    .ap_rst_n                 (ap_rst_n),
    .din_leaf_bft2interface   (din_bft),
    .dout_leaf_interface2bft  (dout_bft),
    .bft_ready                (bft_ready),
    .ap_start                 (ap_start),
    .ap_start_user            (ap_start_user),
    .dout_leaf_interface2user (dout_user),
    .vld_interface2user       (vld_i2u),
    .ack_user2interface       (ack_u2i),
    .din_leaf_user2interface  (din_user),
    .vld_user2interface       (vld_u2i),
    .ack_interface2user       (ack_i2u),
    .overflow                 (overflow)
`ifdef LEAF_BRIDGE_STATS_EN
    ,
    .pkt_in_cnt               (pkt_in_cnt),
    .pkt_out_cnt              (pkt_out_cnt)
`endif
  );

  function automatic logic [PB-1:0] bft_pkt(input logic [3:0] port, input logic [6:0] addr,
                                            input logic [31:0] payload);
    return {1'b1, 5'd0, port, addr, payload};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    ap_rst_n  = 1'b0;
    din_bft   = '0;
    bft_ready = 1'b0;
    ap_start  = 1'b0;
    ack_u2i   = '0;
    din_user  = '0;
    vld_u2i   = '0;
    repeat (2) @(negedge clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vld_u2i   = 4'b1111;
    bft_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (dout_bft !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout_bft); end
    checks++; if (vld_i2u !== 2'b00) begin errors++; $display("FAIL reset_vld got %b want 00", vld_i2u); end
    checks++; if (ack_i2u !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack_i2u); end
    checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b want 00", overflow); end
    checks++; if (ap_start_user !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", ap_start_user); end
    ap_start = 1'b1;
    @(negedge clk);
    checks++; if (ap_start_user !== 1'b1) begin errors++; $display("FAIL start_delay got %b want 1", ap_start_user); end
    ap_start = 1'b0;
    vld_u2i  = '0;
    @(negedge clk);
    checks++; if (ap_start_user !== 1'b0) begin errors++; $display("FAIL start_fall got %b want 0", ap_start_user); end
  endtask

  task automatic test_config_single();
    din_bft = bft_pkt(4'd0, 7'd1, 32'h0000_0032);
    @(negedge clk);
    din_bft               = '0;
    vld_u2i               = 4'b0010;
    din_user[32 +: 32]    = 32'hDEAD_BEEF;
    bft_ready             = 1'b1;
    #1;
    checks++; if (ack_i2u !== 4'b0010) begin errors++; $display("FAIL cfg_ack got %b want 0010", ack_i2u); end
    @(negedge clk);
    checks++;
    if (dout_bft !== {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL cfg_dout0 got %h want %h", dout_bft, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEAD_BEEF});
    end
    din_user[32 +: 32] = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (dout_bft !== {1'b1, 5'd3, 4'd2, 7'd1, 32'h1234_5678}) begin
      errors++; $display("FAIL cfg_dout_seq1 got %h want %h", dout_bft, {1'b1, 5'd3, 4'd2, 7'd1, 32'h1234_5678});
    end
    vld_u2i = '0;
    #1;
    checks++; if (ack_i2u !== 4'b0000) begin errors++; $display("FAIL cfg_ack_idle got %b want 0000", ack_i2u); end
    @(negedge clk);
    checks++; if (dout_bft !== '0) begin errors++; $display("FAIL cfg_dout_idle got %h want 0", dout_bft); end
  endtask

  task automatic test_unconfigured();
    // Out-of-range config must not alias onto a low channel.
    din_bft = bft_pkt(4'd0, 7'd4, 32'h0000_0011);
    @(negedge clk);
    din_bft   = '0;
    vld_u2i   = 4'b1101;
    bft_ready = 1'b1;
    #1;
    checks++; if (ack_i2u !== 4'b0000) begin errors++; $display("FAIL uncfg_ack got %b want 0000", ack_i2u); end
    @(negedge clk);
    checks++; if (dout_bft[PB-1] !== 1'b0) begin errors++; $display("FAIL uncfg_dout_vld got %b want 0", dout_bft[PB-1]); end
    vld_u2i            = 4'b0110;
    din_user[32 +: 32] = 32'hCAFE_0001;
    #1;
    checks++; if (ack_i2u !== 4'b0010) begin errors++; $display("FAIL uncfg_mix_ack got %b want 0010", ack_i2u); end
    @(negedge clk);
    vld_u2i = '0;
    checks++;
    if (dout_bft !== {1'b1, 5'd3, 4'd2, 7'd2, 32'hCAFE_0001}) begin
      errors++; $display("FAIL uncfg_dout got %h want %h", dout_bft, {1'b1, 5'd3, 4'd2, 7'd2, 32'hCAFE_0001});
    end
    bft_ready = 1'b0;
  endtask

  task automatic test_fifo_overflow();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      din_bft = bft_pkt(4'd1, 7'd0, 32'h100 + 32'(k));
    end
    @(negedge clk);
    checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL fifo_full_no_ovf got %b want 00", overflow); end
    din_bft = bft_pkt(4'd1, 7'd0, 32'h108);
    @(negedge clk);
    din_bft = '0;
    checks++; if (overflow !== 2'b01) begin errors++; $display("FAIL fifo_ovf got %b want 01", overflow); end
    checks++; if (vld_i2u !== 2'b01) begin errors++; $display("FAIL fifo_vld got %b want 01", vld_i2u); end
    ack_u2i = 2'b01;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout_user[31:0] !== 32'h100 + 32'(k)) begin
        errors++; $display("FAIL fifo_order[%0d] got %h want %h", k, dout_user[31:0], 32'h100 + 32'(k));
      end
      @(negedge clk);
    end
    checks++; if (vld_i2u[0] !== 1'b0) begin errors++; $display("FAIL fifo_drained got %b want 0", vld_i2u[0]); end
    ack_u2i = '0;
    // Fill channel 1, then push and pop together while full.
    for (int k = 0; k < 8; k++) begin
      din_bft = bft_pkt(4'd2, 7'd0, 32'h200 + 32'(k));
      @(negedge clk);
    end
    din_bft = bft_pkt(4'd2, 7'd0, 32'h208);
    ack_u2i = 2'b10;
    @(negedge clk);
    din_bft = '0;
    checks++; if (overflow !== 2'b01) begin errors++; $display("FAIL fifo_pushpop_ovf got %b want 01", overflow); end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (dout_user[63:32] !== 32'h200 + 32'(k)) begin
        errors++; $display("FAIL fifo1_order[%0d] got %h want %h", k, dout_user[63:32], 32'h200 + 32'(k));
      end
      @(negedge clk);
    end
    ack_u2i = '0;
    checks++; if (vld_i2u !== 2'b00) begin errors++; $display("FAIL fifo1_drained got %b want 00", vld_i2u); end
    // Port 3 has no channel behind it.
    din_bft = bft_pkt(4'd3, 7'd0, 32'h333);
    @(negedge clk);
    din_bft = '0;
    checks++; if (vld_i2u !== 2'b00) begin errors++; $display("FAIL bad_port_vld got %b want 00", vld_i2u); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    logic [PB-1:0] exp_pkt;
    int e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din_bft = bft_pkt(4'd0, 7'(i), 32'((i + 1) * 16 + (i + 1)));
    end
    @(negedge clk);
    din_bft = '0;
    for (int i = 0; i < 4; i++) din_user[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    vld_u2i   = 4'b1111;
    bft_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      e = j % 4;
      exp_ack = 4'b0001 << e;
      #1;
      checks++; if (ack_i2u !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d] got %b want %b", j, ack_i2u, exp_ack); end
      @(negedge clk);
      exp_pkt = {1'b1, 5'(e + 1), 4'(e + 1), 7'(j / 4), 32'hA000_0000 + 32'(e)};
      checks++; if (dout_bft !== exp_pkt) begin errors++; $display("FAIL rr_dout[%0d] got %h want %h", j, dout_bft, exp_pkt); end
    end
    bft_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #1;
      checks++; if (ack_i2u !== 4'b0000) begin errors++; $display("FAIL stall_ack[%0d] got %b want 0000", j, ack_i2u); end
      @(negedge clk);
      checks++; if (dout_bft[PB-1] !== 1'b0) begin errors++; $display("FAIL stall_dout[%0d] got %b want 0", j, dout_bft[PB-1]); end
    end
    bft_ready = 1'b1;
    #1;
    checks++; if (ack_i2u !== 4'b0010) begin errors++; $display("FAIL rr_resume got %b want 0010", ack_i2u); end
    @(negedge clk);
    vld_u2i   = '0;
    bft_ready = 1'b0;
  endtask

  task automatic test_seq_wrap_and_reset();
    do_reset();
    @(negedge clk);
    din_bft  = bft_pkt(4'd0, 7'd3, 32'h0000_0075);
    ap_start = 1'b1;
    @(negedge clk);
    din_bft             = bft_pkt(4'd1, 7'd0, 32'h55);
    vld_u2i             = 4'b1000;
    din_user[96 +: 32]  = 32'hBEEF_0000;
    bft_ready           = 1'b1;
    #1;
    checks++; if (ack_i2u !== 4'b1000) begin errors++; $display("FAIL wrap_ack got %b want 1000", ack_i2u); end
    for (int k = 0; k < 129; k++) begin
      @(negedge clk);
      din_bft = '0;
      checks++;
      if ({dout_bft[PB-1], dout_bft[38:32]} !== {1'b1, 7'(k % 128)}) begin
        errors++; $display("FAIL wrap_seq[%0d] got %b/%0d want 1/%0d", k, dout_bft[PB-1], dout_bft[38:32], k % 128);
      end
    end
    checks++; if (dout_bft[47:39] !== {5'd7, 4'd5}) begin errors++; $display("FAIL wrap_dest got %h want %h", dout_bft[47:39], {5'd7, 4'd5}); end
    checks++; if (vld_i2u !== 2'b01) begin errors++; $display("FAIL pre_rst_vld got %b want 01", vld_i2u); end
    checks++; if (ap_start_user !== 1'b1) begin errors++; $display("FAIL pre_rst_start got %b want 1", ap_start_user); end
    ap_rst_n = 1'b0;
    #1;
    checks++; if (dout_bft !== '0) begin errors++; $display("FAIL mid_rst_dout got %h want 0", dout_bft); end
    checks++; if (vld_i2u !== 2'b00) begin errors++; $display("FAIL mid_rst_vld got %b want 00", vld_i2u); end
    checks++; if (ack_i2u !== 4'b0000) begin errors++; $display("FAIL mid_rst_ack got %b want 0000", ack_i2u); end
    checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL mid_rst_ovf got %b want 00", overflow); end
    checks++; if (ap_start_user !== 1'b0) begin errors++; $display("FAIL mid_rst_start got %b want 0", ap_start_user); end
    @(negedge clk);
    ap_start = 1'b0;
    ap_rst_n = 1'b1;
    @(negedge clk);
    checks++; if (vld_i2u !== 2'b00) begin errors++; $display("FAIL post_rst_vld got %b want 00", vld_i2u); end
    checks++; if (ack_i2u !== 4'b0000) begin errors++; $display("FAIL post_rst_ack got %b want 0000", ack_i2u); end
    checks++; if (dout_bft !== '0) begin errors++; $display("FAIL post_rst_dout got %h want 0", dout_bft); end
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    din_bft   = '0;
    bft_ready = 1'b0;
    ap_start  = 1'b0;
    ack_u2i   = '0;
    din_user  = '0;
    vld_u2i   = '0;
    test_reset();
    test_config_single();
    test_unconfigured();
    test_fifo_overflow();
    test_round_robin();
    test_seq_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
